// File: rtl/tt_io_bist_if.sv
// tt_io_bist_if: core-side pin bundle between the BIST harness and the quick_cpu core.
//   master (harness): drives core_ui_in, core_uio_in, core_rst_n; observes core_uo_out, core_uio_out, core_uio_oe
//   slave  (core)   : the mirror image
interface tt_io_bist_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] core_ui_in;
    logic [WIDTH-1:0] core_uio_in;
    logic             core_rst_n;
    logic [WIDTH-1:0] core_uo_out;
    logic [WIDTH-1:0] core_uio_out;
    logic [WIDTH-1:0] core_uio_oe;

    modport master (
        output core_ui_in, core_uio_in, core_rst_n,
        input  core_uo_out, core_uio_out, core_uio_oe
    );

    modport slave (
        input  core_ui_in, core_uio_in, core_rst_n,
        output core_uo_out, core_uio_out, core_uio_oe
    );
endinterface

// File: rtl/tt_io_bist.sv
// tt_io_bist: pad-to-core harness; transparent in IDLE, otherwise runs an LFSR-driven MISR self-test.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   ena                        : gates only the start condition
//   bist_start, bist_clear     : start on rising edge from IDLE; clear returns DONE to IDLE
//   pad_ui_in, pad_uio_in      : pad-side inputs
//   pad_uo_out, pad_uio_out/oe : pad-side outputs (status byte while not IDLE)
//   core                       : core-side pins (master modport)
//   bist_busy/done/pass        : RST|RUN, DONE, registered signature match
//   signature                  : live MISR value
module tt_io_bist #(
    parameter int                 WIDTH      = 8,
    parameter int                 RUN_CYCLES = 256,
    parameter int                 RST_CYCLES = 4,
    parameter logic [2*WIDTH-1:0] POLY       = 16'hB400,
    parameter logic [2*WIDTH-1:0] SEED       = 16'hACE1,
    parameter logic [2*WIDTH-1:0] EXPECTED   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 bist_start,
    input  logic                 bist_clear,
    input  logic [WIDTH-1:0]     pad_ui_in,
    input  logic [WIDTH-1:0]     pad_uio_in,
    output logic [WIDTH-1:0]     pad_uo_out,
    output logic [WIDTH-1:0]     pad_uio_out,
    output logic [WIDTH-1:0]     pad_uio_oe,
    tt_io_bist_if.master         core,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_pass,
    output logic [2*WIDTH-1:0]   signature
);
    localparam int SW = 2 * WIDTH;
    // One counter serves both the reset hold and the run, so size it for the longer of the two.
    localparam int CMAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
    localparam logic [SW-1:0] SEED_V = (SEED == '0) ? SW'(1) : SEED;

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] lfsr_q, lfsr_d, misr_q, misr_d, lfsr_nx, misr_nx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d, start_q, start_edge, idle;

    assign start_edge = bist_start & ~start_q;
    assign lfsr_nx = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
    assign misr_nx = (misr_q >> 1) ^ (misr_q[0] ? POLY : '0)
                   ^ {core.core_uo_out, core.core_uio_out & core.core_uio_oe};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (start_edge && ena) begin
                state_d = RST;
                cnt_d   = '0;
                lfsr_d  = SEED_V;
                misr_d  = '0;
                pass_d  = 1'b0;
            end
            RST: begin
                cnt_d = (cnt_q == RST_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == RST_LAST) state_d = RUN;
            end
            RUN: begin
                lfsr_d = lfsr_nx;
                misr_d = misr_nx;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == RUN_LAST) begin
                    state_d = DONE;
                    pass_d  = (misr_nx == EXPECTED);
                end
            end
            DONE: if (bist_clear) begin
                state_d = IDLE;
                pass_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // start_q resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_V;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            start_q <= bist_start;
        end
    end

    assign idle      = (state_q == IDLE);
    assign bist_busy = (state_q == RST) || (state_q == RUN);
    assign bist_done = (state_q == DONE);
    assign bist_pass = pass_q;
    assign signature = misr_q;

    assign core.core_ui_in  = idle ? pad_ui_in  : lfsr_q[WIDTH-1:0];
    assign core.core_uio_in = idle ? pad_uio_in : lfsr_q[SW-1:WIDTH];
    assign core.core_rst_n  = idle ? rst_n      : (state_q != RST);

    // Status byte on uo_out while under test: {busy, done, pass, 0...}.
    assign pad_uo_out  = idle ? core.core_uo_out
                              : WIDTH'({bist_busy, bist_done, bist_pass}) << (WIDTH - 3);
    assign pad_uio_out = idle ? core.core_uio_out : '0;
    assign pad_uio_oe  = idle ? core.core_uio_oe  : '0;
endmodule

// File: tb/tb_tt_io_bist.sv
// tb_tt_io_bist: directed self-checking bench for tt_io_bist (RUN_CYCLES=8, RST_CYCLES=4).
module tb_tt_io_bist;
    logic        clk = 1'b0;
    logic        rst_n, ena, bist_start, bist_clear;
    logic [7:0]  pad_ui_in, pad_uio_in, pad_uo_out, pad_uio_out, pad_uio_oe;
    logic        bist_busy, bist_done, bist_pass;
    logic [15:0] signature;
    int          total = 0, bad = 0;
    int          rst_low, busy_n, bad_pad, done_at;
    logic [15:0] in0, in1;

    tt_io_bist_if #(.WIDTH(8)) cif();

    tt_io_bist #(
        .WIDTH(8), .RUN_CYCLES(8), .RST_CYCLES(4),
        .POLY(16'hB400), .SEED(16'hACE1), .EXPECTED(16'h0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .bist_start(bist_start), .bist_clear(bist_clear),
        .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
        .pad_uo_out(pad_uo_out), .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe),
        .core(cif),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
        .signature(signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ui, uio, uo, cuio, oe;
        logic [7:0] e_cui, e_cuio, e_puo, e_puio, e_poe;
    } pt_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_core(input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
        cif.core_uo_out  = uo;
        cif.core_uio_out = uio;
        cif.core_uio_oe  = oe;
    endtask

    // Start a run and follow it to DONE (40-cycle bound), driving core outputs only on RUN cycle inj.
    task automatic run_bist(input int inj, input logic [7:0] uo, input logic [7:0] uio,
                            input logic [7:0] oe, input logic drop_ena);
        int ri;
        ri = 0; rst_low = 0; busy_n = 0; bad_pad = 0; done_at = 0; in0 = '0; in1 = '0;
        @(negedge clk);
        bist_start = 1'b1;
        for (int n = 1; n <= 40 && done_at == 0; n++) begin
            @(negedge clk);
            bist_start = 1'b0;
            if (drop_ena) ena = 1'b0;
            set_core(8'h00, 8'h00, 8'h00);
            if (!cif.core_rst_n) rst_low++;
            if (bist_busy) begin
                busy_n++;
                if (pad_uo_out !== 8'h80) bad_pad++;
            end
            if (bist_busy && cif.core_rst_n) begin
                if (ri == 0) in0 = {cif.core_uio_in, cif.core_ui_in};
                if (ri == 1) in1 = {cif.core_uio_in, cif.core_ui_in};
                if (ri == inj) set_core(uo, uio, oe);
                ri++;
            end
            if (bist_done) done_at = n;
        end
        ena = 1'b1;
    endtask

    task automatic clear_and_check();
        @(negedge clk);
        bist_clear = 1'b1;
        @(negedge clk);
        bist_clear = 1'b0;
        set_core(8'h3C, 8'h00, 8'hF0);
        #1;
        chk("clear done", bist_done, 0);
        chk("clear pass", bist_pass, 0);
        chk("clear pad_uo", pad_uo_out, 8'h3C);
        chk("clear pad_oe", pad_uio_oe, 8'hF0);
    endtask

    pt_t pt [3];

    initial begin
        pt[0] = '{8'h5A, 8'h00, 8'h3C, 8'h00, 8'hF0, 8'h5A, 8'h00, 8'h3C, 8'h00, 8'hF0};
        pt[1] = '{8'hA5, 8'hC3, 8'h81, 8'h7E, 8'h0F, 8'hA5, 8'hC3, 8'h81, 8'h7E, 8'h0F};
        pt[2] = '{8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hFF, 8'hFF};

        rst_n = 1'b0; ena = 1'b1; bist_start = 1'b0; bist_clear = 1'b0;
        pad_ui_in = 8'h00; pad_uio_in = 8'h00;
        set_core(8'h00, 8'h00, 8'h00);
        #12;
        chk("rst busy", bist_busy, 0);
        chk("rst done", bist_done, 0);
        chk("rst pass", bist_pass, 0);
        chk("rst sig", signature, 0);
        chk("rst core_rst_n", cif.core_rst_n, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pad_ui_in = pt[i].ui; pad_uio_in = pt[i].uio;
            set_core(pt[i].uo, pt[i].cuio, pt[i].oe);
            #1;
            chk($sformatf("pt%0d core_ui", i), cif.core_ui_in, pt[i].e_cui);
            chk($sformatf("pt%0d core_uio", i), cif.core_uio_in, pt[i].e_cuio);
            chk($sformatf("pt%0d pad_uo", i), pad_uo_out, pt[i].e_puo);
            chk($sformatf("pt%0d pad_uio", i), pad_uio_out, pt[i].e_puio);
            chk($sformatf("pt%0d pad_oe", i), pad_uio_oe, pt[i].e_poe);
            chk($sformatf("pt%0d core_rst_n", i), cif.core_rst_n, 1);
            chk($sformatf("pt%0d busy", i), bist_busy, 0);
        end

        // Clean run: timing, LFSR sequence, zero signature.
        run_bist(-1, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("A rst_low", rst_low, 4);
        chk("A busy cycles", busy_n, 12);
        chk("A done cycle", done_at, 13);
        chk("A pad 0x80 while busy", bad_pad, 0);
        chk("A lfsr0", in0, 16'hACE1);
        chk("A lfsr1", in1, 16'hE270);
        chk("A sig", signature, 16'h0000);
        chk("A pass", bist_pass, 1);
        set_core(8'hFF, 8'hFF, 8'hFF);
        #1;
        chk("A pad_uo done", pad_uo_out, 8'h60);
        chk("A pad_uio done", pad_uio_out, 0);
        chk("A pad_oe done", pad_uio_oe, 0);
        chk("A core_rst_n done", cif.core_rst_n, 1);
        @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        @(negedge clk);
        chk("A start ignored in done", bist_done, 1);
        clear_and_check();

        // Single-cycle fault on uo_out at first RUN cycle.
        run_bist(0, 8'h01, 8'h00, 8'h00, 1'b0);
        chk("B done cycle", done_at, 13);
        chk("B sig", signature, 16'h0002);
        chk("B pass", bist_pass, 0);
        chk("B pad_uo", pad_uo_out, 8'h40);
        clear_and_check();

        // Fault on enabled uio bit exercises the feedback polynomial; ena dropped mid-run.
        run_bist(0, 8'h00, 8'h01, 8'h01, 1'b1);
        chk("C done cycle", done_at, 13);
        chk("C sig", signature, 16'h02D0);
        chk("C pass", bist_pass, 0);
        clear_and_check();

        // uio_out without oe must be masked out of the signature.
        run_bist(3, 8'h00, 8'hFF, 8'h00, 1'b0);
        chk("D sig masked", signature, 16'h0000);
        chk("D pass", bist_pass, 1);
        @(negedge clk);
        bist_start = 1'b1; bist_clear = 1'b1;
        @(negedge clk);
        bist_clear = 1'b0;
        chk("E clear wins done", bist_done, 0);
        @(negedge clk);
        @(negedge clk);
        chk("E edge consumed", bist_busy, 0);
        bist_start = 1'b0;

        // ena low blocks the start; clear in IDLE does nothing.
        @(negedge clk);
        ena = 1'b0; bist_start = 1'b1; bist_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("F ena gates start", bist_busy, 0);
        chk("F clear idle", bist_done, 0);
        ena = 1'b1; bist_start = 1'b0; bist_clear = 1'b0;

        // Abort mid-RUN, then start held across reset release.
        @(negedge clk);
        bist_start = 1'b1;
        set_core(8'h55, 8'h00, 8'h00);
        repeat (7) @(negedge clk);
        chk("G busy pre-abort", bist_busy, 1);
        chk("G sig pre-abort", signature, 16'h7F80);
        #2 rst_n = 1'b0;
        #1;
        chk("G abort core_rst_n", cif.core_rst_n, 0);
        chk("G abort sig", signature, 0);
        chk("G abort busy", bist_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("G held start no run", bist_busy, 0);
        bist_start = 1'b0;
        @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        chk("G new edge busy", bist_busy, 1);
        chk("G new edge core_rst_n", cif.core_rst_n, 0);
        bist_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tt_io_bist.md
Name: tt_io_bist

Overview:
- Parametrised pin-level harness between the Tiny Tapeout pad interface (ui_in/uo_out/uio_*) and the quick_cpu core.
- Mission mode: transparent pass-through of all pins.
- BIST mode: drives pseudo-random stimulus into the core, compacts the core's outputs into a MISR signature over a fixed cycle count, then reports pass/fail against a built-in expected signature.
- Puts the bench's drive-pins/watch-pins role in silicon so the part can self-check on the board.

Parameters:
- WIDTH, 8, pad bus width; LFSR/MISR width is 2*WIDTH.
- RUN_CYCLES, 256, core clock cycles compacted per BIST run (1..65535).
- RST_CYCLES, 4, cycles core_rst_n is held low before RUN (>=1).
- POLY, 16'hB400, Galois feedback mask for both LFSR and MISR, width 2*WIDTH.
- SEED, 16'hACE1, LFSR seed, width 2*WIDTH; zero is replaced by 1.
- EXPECTED, 0, golden MISR value, width 2*WIDTH.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- ena in 1: design selected; when low, BIST start is ignored and pass-through stays active.
- bist_start in 1: rising-edge sensitive; starts a run from IDLE.
- bist_clear in 1: returns DONE to IDLE.
- pad_ui_in in WIDTH: pad side of ui_in.
- pad_uio_in in WIDTH: pad side of uio_in.
- pad_uo_out out WIDTH: pad side of uo_out.
- pad_uio_out out WIDTH: pad side of uio_out.
- pad_uio_oe out WIDTH: pad side of uio_oe.
- core_ui_in out WIDTH: core side of ui_in.
- core_uio_in out WIDTH: core side of uio_in.
- core_rst_n out 1: reset to the core.
- core_uo_out in WIDTH: core uo_out.
- core_uio_out in WIDTH: core uio_out.
- core_uio_oe in WIDTH: core uio_oe.
- bist_busy out 1: high in RST or RUN.
- bist_done out 1: high in DONE.
- bist_pass out 1: valid in DONE.
- signature out 2*WIDTH: current MISR value.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - LFSR = SEED (or 1 if SEED==0); MISR = 0; cycle counter = 0.
  - bist_busy = bist_done = bist_pass = 0; signature = 0.
  - core_rst_n = 0 while rst_n is low.
- States: IDLE, RST, RUN, DONE.
- IDLE:
  - Pass-through: core_ui_in = pad_ui_in, core_uio_in = pad_uio_in, pad_* outs = core_* outs, core_rst_n = rst_n.
  - bist_start 0->1 (registered edge detect) with ena=1 -> RST; counter = 0, LFSR reloaded, MISR cleared.
- RST:
  - core_rst_n = 0 for exactly RST_CYCLES cycles; core inputs driven from LFSR.
  - The LFSR does not advance in RST.
  - Then -> RUN with counter = 0.
- RUN:
  - core_rst_n = 1.
  - core_ui_in = LFSR[WIDTH-1:0]; core_uio_in = LFSR[2W-1:W].
  - Each cycle:
    - LFSR: if lsb, s = (s>>1)^POLY, else s>>1.
    - MISR: m = galois(m) XOR {core_uo_out, core_uio_out & core_uio_oe}.
    - Counter increments.
  - After exactly RUN_CYCLES compaction cycles -> DONE.
  - bist_pass is registered = (MISR == EXPECTED) on the DONE entry edge.
- DONE:
  - MISR, LFSR and counter are frozen; core_rst_n = 1; core inputs hold the last LFSR value.
  - bist_clear=1 -> IDLE, with bist_pass and bist_done cleared.
  - bist_start is ignored here.
- Pad outputs in RST/RUN/DONE:
  - pad_uo_out = {bist_busy, bist_done, bist_pass, 0...}, MSB first.
  - pad_uio_oe = 0; pad_uio_out = 0.
- ena deasserted mid-run: the run continues. ena gates only the start condition.
- bist_start held high across DONE->IDLE: no restart; a new rising edge is required.
- bist_clear in states other than DONE: ignored.
- Simultaneous bist_start edge and bist_clear in DONE: clear wins, and the edge is consumed.
- rst_n asserted mid-run: immediate return to IDLE, all state per reset.
- Counter width is ceil(log2(RUN_CYCLES+1)), with no wrap.

Test Plan:
- Pass-through: IDLE, pad_ui_in=0x5A, core_uo_out=0x3C, core_uio_oe=0xF0 -> core_ui_in=0x5A, pad_uo_out=0x3C, pad_uio_oe=0xF0, core_rst_n=1, bist_busy=0.
- Reset timing: RST_CYCLES=4, RUN_CYCLES=8, start pulse -> core_rst_n low exactly 4 cycles; bist_busy high exactly 12 cycles; bist_done rises on cycle 13 after the edge is registered; pad_uo_out=0x80 while busy.
- LFSR: SEED=0xACE1, POLY=0xB400 -> first RUN cycle core_ui_in=0xE1, core_uio_in=0xAC; second cycle {uio,ui}=0xE270.
- Zero compaction: core outputs all 0, EXPECTED=0 -> signature=0x0000, bist_pass=1, pad_uo_out=0x60 in DONE.
- Fault detect: core_uo_out=0x01 for one RUN cycle only, EXPECTED=0 -> signature!=0, bist_pass=0, pad_uo_out=0x40; bist_clear -> IDLE, pass-through restored.
- Abort and retrigger: rst_n low mid-RUN -> IDLE, signature=0, core_rst_n=0 asynchronously; bist_start held high after reset release -> no run until a new rising edge.
